// File: rtl/add8u_err_mon.sv
// Error monitor for an approximate 8-bit unsigned adder: measures |error| sum,
// squared-error sum, worst-case error and error count over 2^WIN_LOG2 samples.
module add8u_err_mon #(
  parameter int WIN_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            a,
  input  logic [7:0]            b,
  input  logic [8:0]            o_apx,
  output logic                  busy,
  output logic                  done,
  output logic [WIN_LOG2+8:0]   sum_abs,
  output logic [WIN_LOG2+17:0]  sum_sq,
  output logic [8:0]            wce,
  output logic [WIN_LOG2:0]     err_cnt
);

  localparam int AW = WIN_LOG2 + 9;
  localparam int QW = WIN_LOG2 + 18;
  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dcnt_q, dcnt_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [8:0]     e_p1_q, e_p1_d;
  logic           nz_p1_q, nz_p1_d;
  logic           vld_p1_q, vld_p1_d;
  logic [AW-1:0]  sum_abs_q, sum_abs_d;
  logic [QW-1:0]  sum_sq_q, sum_sq_d;
  logic [8:0]     wce_q, wce_d;
  logic [CW-1:0]  err_cnt_q, err_cnt_d;
  logic [17:0]    sq_p1;
  logic           accept;

  // Magnitude of (approximate - exact); both 9-bit unsigned, result fits 9 bits.
  function automatic logic [8:0] abs_err(input logic [8:0] apx, input logic [8:0] exact);
    logic signed [9:0] d;
    d = $signed({1'b0, apx}) - $signed({1'b0, exact});
    return d[9] ? 9'(-d) : d[8:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    sum_abs_d = sum_abs_q;
    sum_sq_d  = sum_sq_q;
    wce_d     = wce_q;
    err_cnt_d = err_cnt_q;
    accept    = in_valid && in_ready_q && !clear;

    // stage 1: error magnitude of the accepted sample
    e_p1_d   = abs_err(o_apx, {1'b0, a} + {1'b0, b});
    nz_p1_d  = (e_p1_d != 9'd0);
    vld_p1_d = accept;

    // stage 2: accumulate
    sq_p1 = 18'(e_p1_q) * 18'(e_p1_q);
    if (vld_p1_q) begin
      sum_abs_d = sum_abs_q + AW'(e_p1_q);
      sum_sq_d  = sum_sq_q + QW'(sq_p1);
      err_cnt_d = err_cnt_q + CW'(nz_p1_q);
      if (e_p1_q > wce_q) wce_d = e_p1_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          sum_abs_d = '0;
          sum_sq_d  = '0;
          wce_d     = '0;
          err_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DRAIN;
            dcnt_d  = 1'b0;
          end
        end
      end
      DRAIN: begin
        dcnt_d = 1'b1;
        if (dcnt_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including the sample still in stage 1.
    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      vld_p1_d  = 1'b0;
      sum_abs_d = '0;
      sum_sq_d  = '0;
      wce_d     = '0;
      err_cnt_d = '0;
    end

    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dcnt_q     <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      sum_abs_q  <= '0;
      sum_sq_q   <= '0;
      wce_q      <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_p1_q   <= vld_p1_d;
      sum_abs_q  <= sum_abs_d;
      sum_sq_q   <= sum_sq_d;
      wce_q      <= wce_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Stage-1 data is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    e_p1_q  <= e_p1_d;
    nz_p1_q <= nz_p1_d;
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum_abs  = sum_abs_q;
  assign sum_sq   = sum_sq_q;
  assign wce      = wce_q;
  assign err_cnt  = err_cnt_q;

endmodule
